// File: rtl/roi_track_pkg.sv
// Shared encodings for the ROI tracker: per-channel state codes and the
// field order of a packed {up,down,left,right} box (right in the LSBs).
package roi_track_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_LOST    = 2'd3
  } trk_state_e;

  localparam int F_RIGHT = 0;
  localparam int F_LEFT  = 1;
  localparam int F_DOWN  = 2;
  localparam int F_UP    = 3;
  localparam int NFIELD  = 4;

endpackage

// File: rtl/roi_track_ch.sv
// One tracked region: search window, bounding-box accumulation over a frame,
// commit at frame end and miss counting.
//   state   | meaning
//   IDLE    | never locked since reset, no window
//   ACQUIRE | locked, searching around the latched seed
//   TRACK   | box committed, searching around the last box
//   LOST    | MISS_LIMIT empty frames in a row, no window
module roi_track_ch
  import roi_track_pkg::*;
#(
  parameter int CW         = 11,
  parameter int MARGIN     = 10,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int MISS_LIMIT = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 lock_ev_i,
  input  logic                 frame_end_i,
  input  logic [CW-1:0]        px_x_i,
  input  logic [CW-1:0]        px_y_i,
  input  logic                 dark_i,
  input  logic                 masked_i,
  input  logic [NFIELD*CW-1:0] seed_i,
  output logic                 in_win_o,
  output logic [NFIELD*CW-1:0] box_o,
  output logic [CW-1:0]        high_o,
  output logic [CW-1:0]        wide_o,
  output logic                 valid_o,
  output logic [1:0]           state_o
);

  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT);
  localparam logic [CW:0]   MARG     = (CW+1)'(MARGIN);
  localparam logic [CW:0]   Y_MAX    = (CW+1)'(IMG_H - 1);
  localparam logic [CW:0]   X_MAX    = (CW+1)'(IMG_W - 1);

  trk_state_e          state_q;
  logic [NFIELD*CW-1:0] seed_q, box_q;
  logic [CW-1:0]       high_q, wide_q;
  logic [MW-1:0]       miss_q, miss_d;
  logic                seen_q;
  logic [CW-1:0]       min_x_q, max_x_q, min_y_q, max_y_q;

  logic [NFIELD*CW-1:0] base;
  logic [CW:0]         b_up, b_dn, b_lf, b_rt;
  logic [CW:0]         w_up, w_dn, w_lf, w_rt;
  logic [CW:0]         x_w, y_w;
  logic                active, hit;

  // Window math is one bit wider so the +MARGIN side cannot wrap before clamping.
  always_comb begin
    base     = (state_q == ST_ACQUIRE) ? seed_q : box_q;
    b_up     = {1'b0, base[F_UP*CW    +: CW]};
    b_dn     = {1'b0, base[F_DOWN*CW  +: CW]};
    b_lf     = {1'b0, base[F_LEFT*CW  +: CW]};
    b_rt     = {1'b0, base[F_RIGHT*CW +: CW]};
    w_up     = (b_up >= MARG) ? (b_up - MARG) : '0;
    w_lf     = (b_lf >= MARG) ? (b_lf - MARG) : '0;
    w_dn     = ((b_dn + MARG) > Y_MAX) ? Y_MAX : (b_dn + MARG);
    w_rt     = ((b_rt + MARG) > X_MAX) ? X_MAX : (b_rt + MARG);
    x_w      = {1'b0, px_x_i};
    y_w      = {1'b0, px_y_i};
    active   = (state_q == ST_ACQUIRE) || (state_q == ST_TRACK);
    in_win_o = active && (y_w >= w_up) && (y_w <= w_dn) &&
               (x_w >= w_lf) && (x_w <= w_rt);
    hit      = in_win_o && dark_i && !masked_i;
    miss_d   = miss_q + MW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      seed_q  <= '0;
      box_q   <= '0;
      high_q  <= '0;
      wide_q  <= '0;
      miss_q  <= '0;
      seen_q  <= 1'b0;
      min_x_q <= '0;
      max_x_q <= '0;
      min_y_q <= '0;
      max_y_q <= '0;
    end else if (lock_ev_i) begin
      // A lock overrides any frame commit landing on the same cycle.
      state_q <= ST_ACQUIRE;
      seed_q  <= seed_i;
      miss_q  <= '0;
      seen_q  <= 1'b0;
      min_x_q <= '0;
      max_x_q <= '0;
      min_y_q <= '0;
      max_y_q <= '0;
    end else if (frame_end_i) begin
      seen_q  <= 1'b0;
      min_x_q <= '0;
      max_x_q <= '0;
      min_y_q <= '0;
      max_y_q <= '0;
      if (active) begin
        if (seen_q) begin
          box_q   <= {min_y_q, max_y_q, min_x_q, max_x_q};
          high_q  <= max_y_q - min_y_q;
          wide_q  <= max_x_q - min_x_q;
          miss_q  <= '0;
          state_q <= ST_TRACK;
        end else if (miss_q != MISS_MAX) begin
          miss_q <= miss_d;
          if (miss_d == MISS_MAX) state_q <= ST_LOST;
        end
      end
    end else if (hit) begin
      seen_q <= 1'b1;
      if (!seen_q || (px_x_i < min_x_q)) min_x_q <= px_x_i;
      if (!seen_q || (px_x_i > max_x_q)) max_x_q <= px_x_i;
      if (!seen_q || (px_y_i < min_y_q)) min_y_q <= px_y_i;
      if (!seen_q || (px_y_i > max_y_q)) max_y_q <= px_y_i;
    end
  end

  assign box_o   = box_q;
  assign high_o  = high_q;
  assign wide_o  = wide_q;
  assign valid_o = (state_q == ST_TRACK);
  assign state_o = state_q;

endmodule

// File: rtl/roi_track.sv
// Multi-region dark-object tracker: lock-request synchroniser, frame-end
// detection, LCD-to-image coordinate mapping and lowest-channel-wins masking.
module roi_track
  import roi_track_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int CW         = 11,
  parameter int MARGIN     = 10,
  parameter int H_OFFSET   = 79,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int FEND_X     = 700,
  parameter int FEND_Y     = 480,
  parameter int MISS_LIMIT = 3
) (
  input  logic                     module_clk,
  input  logic                     module_rst,
  input  logic                     touch_key,
  input  logic                     din_val,
  input  logic                     din,
  input  logic [CW-1:0]            lcd_pixel_xpos,
  input  logic [CW-1:0]            lcd_pixel_ypos,
  input  logic [NCH*NFIELD*CW-1:0] seed_box,
  output logic [NCH*NFIELD*CW-1:0] trk_box,
  output logic [NCH*CW-1:0]        trk_high,
  output logic [NCH*CW-1:0]        trk_wide,
  output logic [NCH-1:0]           trk_valid,
  output logic [NCH*2-1:0]         trk_state
);

  logic          touch_s1_q, touch_s2_q, touch_s3_q;
  logic          fend_match_q;
  logic          lock_ev, fend_match, frame_end, dark;
  logic [CW-1:0] px_x, px_y;
  logic [NCH-1:0] in_win, masked;

  always_ff @(posedge module_clk) begin
    if (module_rst) begin
      touch_s1_q   <= 1'b0;
      touch_s2_q   <= 1'b0;
      touch_s3_q   <= 1'b0;
      fend_match_q <= 1'b0;
    end else begin
      touch_s1_q   <= touch_key;
      touch_s2_q   <= touch_s1_q;
      touch_s3_q   <= touch_s2_q;
      fend_match_q <= fend_match;
    end
  end

  assign lock_ev    = touch_s2_q & ~touch_s3_q;
  assign fend_match = (lcd_pixel_xpos == CW'(FEND_X)) && (lcd_pixel_ypos == CW'(FEND_Y));
  assign frame_end  = fend_match & ~fend_match_q;
  assign px_x       = lcd_pixel_xpos - CW'(H_OFFSET);
  assign px_y       = lcd_pixel_ypos;
  assign dark       = din_val & ~din;

  // A channel is masked when any lower-index channel's window covers the pixel.
  always_comb begin
    masked = '0;
    for (int k = 0; k < NCH; k++) begin
      masked[k] = |(in_win & ((NCH'(1) << k) - NCH'(1)));
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    roi_track_ch #(
      .CW         (CW),
      .MARGIN     (MARGIN),
      .IMG_W      (IMG_W),
      .IMG_H      (IMG_H),
      .MISS_LIMIT (MISS_LIMIT)
    ) u_ch (
      .clk_i       (module_clk),
      .rst_i       (module_rst),
      .lock_ev_i   (lock_ev),
      .frame_end_i (frame_end),
      .px_x_i      (px_x),
      .px_y_i      (px_y),
      .dark_i      (dark),
      .masked_i    (masked[k]),
      .seed_i      (seed_box[k*NFIELD*CW +: NFIELD*CW]),
      .in_win_o    (in_win[k]),
      .box_o       (trk_box[k*NFIELD*CW +: NFIELD*CW]),
      .high_o      (trk_high[k*CW +: CW]),
      .wide_o      (trk_wide[k*CW +: CW]),
      .valid_o     (trk_valid[k]),
      .state_o     (trk_state[2*k +: 2])
    );
  end

endmodule

// File: tb/tb_roi_track.sv
// Directed bench for roi_track: a frame-level model predicts every output and
// is compared each cycle; literal expectations pin the model at key points.
module tb_roi_track;

  localparam int NCH = 2, CW = 11, MARGIN = 10, H_OFFSET = 79;
  localparam int IMG_W = 640, IMG_H = 480, FEND_X = 700, FEND_Y = 480, MISS_LIMIT = 3;

  logic                  module_clk = 1'b0;
  logic                  module_rst, touch_key, din_val, din;
  logic [CW-1:0]         lcd_pixel_xpos, lcd_pixel_ypos;
  logic [NCH*4*CW-1:0]   seed_box, trk_box;
  logic [NCH*CW-1:0]     trk_high, trk_wide;
  logic [NCH-1:0]        trk_valid;
  logic [NCH*2-1:0]      trk_state;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  // Model: state codes 0 idle, 1 acquire, 2 track, 3 lost.
  int m_state[NCH], m_miss[NCH];
  int m_up[NCH], m_dn[NCH], m_lf[NCH], m_rt[NCH];
  int s_up[NCH], s_dn[NCH], s_lf[NCH], s_rt[NCH];
  int p_up[NCH], p_dn[NCH], p_lf[NCH], p_rt[NCH];
  bit a_seen[NCH];
  int a_x0[NCH], a_x1[NCH], a_y0[NCH], a_y1[NCH];

  roi_track #(
    .NCH(NCH), .CW(CW), .MARGIN(MARGIN), .H_OFFSET(H_OFFSET), .IMG_W(IMG_W),
    .IMG_H(IMG_H), .FEND_X(FEND_X), .FEND_Y(FEND_Y), .MISS_LIMIT(MISS_LIMIT)
  ) dut (
    .module_clk(module_clk), .module_rst(module_rst), .touch_key(touch_key),
    .din_val(din_val), .din(din), .lcd_pixel_xpos(lcd_pixel_xpos),
    .lcd_pixel_ypos(lcd_pixel_ypos), .seed_box(seed_box), .trk_box(trk_box),
    .trk_high(trk_high), .trk_wide(trk_wide), .trk_valid(trk_valid),
    .trk_state(trk_state)
  );

  always #5 module_clk = ~module_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dbox(input int k, input int f);
    return int'(trk_box[(k*4+f)*CW +: CW]);
  endfunction

  function automatic bit m_in_win(input int k, input int x, input int y);
    int bu, bd, bl, br, wu, wd, wl, wr;
    if (m_state[k] == 1) begin
      bu = s_up[k]; bd = s_dn[k]; bl = s_lf[k]; br = s_rt[k];
    end else if (m_state[k] == 2) begin
      bu = m_up[k]; bd = m_dn[k]; bl = m_lf[k]; br = m_rt[k];
    end else begin
      return 1'b0;
    end
    wu = (bu - MARGIN < 0) ? 0 : bu - MARGIN;
    wl = (bl - MARGIN < 0) ? 0 : bl - MARGIN;
    wd = (bd + MARGIN > IMG_H - 1) ? IMG_H - 1 : bd + MARGIN;
    wr = (br + MARGIN > IMG_W - 1) ? IMG_W - 1 : br + MARGIN;
    return (y >= wu) && (y <= wd) && (x >= wl) && (x <= wr);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NCH; k++) begin
      m_state[k] = 0; m_miss[k] = 0; a_seen[k] = 0;
      m_up[k] = 0; m_dn[k] = 0; m_lf[k] = 0; m_rt[k] = 0;
    end
  endtask

  task automatic m_lock();
    for (int k = 0; k < NCH; k++) begin
      s_up[k] = p_up[k]; s_dn[k] = p_dn[k]; s_lf[k] = p_lf[k]; s_rt[k] = p_rt[k];
      m_state[k] = 1; m_miss[k] = 0; a_seen[k] = 0;
    end
  endtask

  task automatic m_commit();
    for (int k = 0; k < NCH; k++) begin
      if (m_state[k] == 1 || m_state[k] == 2) begin
        if (a_seen[k]) begin
          m_up[k] = a_y0[k]; m_dn[k] = a_y1[k]; m_lf[k] = a_x0[k]; m_rt[k] = a_x1[k];
          m_state[k] = 2; m_miss[k] = 0;
        end else begin
          m_miss[k]++;
          if (m_miss[k] == MISS_LIMIT) m_state[k] = 3;
        end
      end
      a_seen[k] = 0;
    end
  endtask

  task automatic set_seed(input int k, input int u, input int d, input int l, input int r);
    p_up[k] = u; p_dn[k] = d; p_lf[k] = l; p_rt[k] = r;
    seed_box[(k*4+3)*CW +: CW] = CW'(u);
    seed_box[(k*4+2)*CW +: CW] = CW'(d);
    seed_box[(k*4+1)*CW +: CW] = CW'(l);
    seed_box[(k*4+0)*CW +: CW] = CW'(r);
  endtask

  task automatic idle(input int n);
    lcd_pixel_xpos = '0; lcd_pixel_ypos = '0; din_val = 1'b0; din = 1'b1;
    repeat (n) begin @(posedge module_clk); #1; end
  endtask

  // Drive one image pixel (x,y); the model credits the lowest channel whose window holds it.
  task automatic px(input int x, input int y, input bit val, input bit d);
    bit done;
    lcd_pixel_xpos = CW'((x + H_OFFSET) % 2048);
    lcd_pixel_ypos = CW'(y);
    din_val = val; din = d;
    @(posedge module_clk); #1;
    done = 0;
    if (val && !d) begin
      for (int k = 0; k < NCH; k++) begin
        if (!done && m_in_win(k, x, y)) begin
          done = 1;
          if (!a_seen[k]) begin
            a_x0[k] = x; a_x1[k] = x; a_y0[k] = y; a_y1[k] = y; a_seen[k] = 1;
          end else begin
            if (x < a_x0[k]) a_x0[k] = x;
            if (x > a_x1[k]) a_x1[k] = x;
            if (y < a_y0[k]) a_y0[k] = y;
            if (y > a_y1[k]) a_y1[k] = y;
          end
        end
      end
    end
  endtask

  task automatic rect(input int y0, input int y1, input int x0, input int x1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) px(x, y, 1'b1, 1'b0);
  endtask

  // Frame-end coordinate held two cycles: only the first may commit.
  task automatic frame_end_seq();
    lcd_pixel_xpos = CW'(FEND_X); lcd_pixel_ypos = CW'(FEND_Y); din_val = 1'b0; din = 1'b1;
    @(posedge module_clk); #1;
    m_commit();
    @(posedge module_clk); #1;
    idle(1);
  endtask

  task automatic do_lock(input bit with_fe);
    touch_key = 1'b1;
    idle(2);
    if (with_fe) begin
      lcd_pixel_xpos = CW'(FEND_X); lcd_pixel_ypos = CW'(FEND_Y);
    end
    @(posedge module_clk); #1;
    m_lock();
    touch_key = 1'b0;
    idle(3);
  endtask

  task automatic expect_ch(input string tag, input int k, input int u, input int d,
                           input int l, input int r, input int hi, input int wd, input int st);
    check({tag, "_up"},    dbox(k, 3), u);
    check({tag, "_down"},  dbox(k, 2), d);
    check({tag, "_left"},  dbox(k, 1), l);
    check({tag, "_right"}, dbox(k, 0), r);
    check({tag, "_high"},  int'(trk_high[k*CW +: CW]), hi);
    check({tag, "_wide"},  int'(trk_wide[k*CW +: CW]), wd);
    check({tag, "_state"}, int'(trk_state[2*k +: 2]), st);
    check({tag, "_valid"}, int'(trk_valid[k]), (st == 2) ? 1 : 0);
    check({tag, "_model_box"}, m_up[k]*1000000 + m_dn[k]*10000 + m_lf[k]*100 + m_rt[k] % 100,
          u*1000000 + d*10000 + l*100 + r % 100);
    check({tag, "_model_state"}, m_state[k], st);
  endtask

  always @(negedge module_clk) begin
    if (chk_en) begin
      for (int k = 0; k < NCH; k++) begin
        check($sformatf("cyc_state%0d", k), int'(trk_state[2*k +: 2]), m_state[k]);
        check($sformatf("cyc_up%0d", k),    dbox(k, 3), m_up[k]);
        check($sformatf("cyc_down%0d", k),  dbox(k, 2), m_dn[k]);
        check($sformatf("cyc_left%0d", k),  dbox(k, 1), m_lf[k]);
        check($sformatf("cyc_right%0d", k), dbox(k, 0), m_rt[k]);
        check($sformatf("cyc_high%0d", k),  int'(trk_high[k*CW +: CW]), m_dn[k] - m_up[k]);
        check($sformatf("cyc_wide%0d", k),  int'(trk_wide[k*CW +: CW]), m_rt[k] - m_lf[k]);
        check($sformatf("cyc_valid%0d", k), int'(trk_valid[k]), (m_state[k] == 2) ? 1 : 0);
      end
    end
  end

  initial begin
    module_rst = 1'b1; touch_key = 1'b0; din_val = 1'b0; din = 1'b1;
    lcd_pixel_xpos = '0; lcd_pixel_ypos = '0; seed_box = '0;
    m_reset();
    for (int k = 0; k < NCH; k++) set_seed(k, 0, 0, 0, 0);
    repeat (3) @(posedge module_clk);
    #1;
    chk_en = 1;
    expect_ch("rst0", 0, 0, 0, 0, 0, 0, 0, 0);
    expect_ch("rst1", 1, 0, 0, 0, 0, 0, 0, 0);
    module_rst = 1'b0;
    idle(2);

    // First acquisition on ch0; ch1 sees nothing
    set_seed(0, 100, 120, 200, 260);
    set_seed(1, 300, 320, 400, 420);
    do_lock(1'b0);
    check("lock_state0", int'(trk_state[1:0]), 1);
    check("lock_state1", int'(trk_state[3:2]), 1);
    rect(105, 115, 210, 250);
    px(230, 100, 1'b1, 1'b1);
    px(230, 100, 1'b0, 1'b0);
    frame_end_seq();
    expect_ch("acq0", 0, 105, 115, 210, 250, 10, 40, 2);

    // Object drifts +5 in x per frame
    rect(105, 115, 215, 255);
    frame_end_seq();
    expect_ch("drift1", 0, 105, 115, 215, 255, 10, 40, 2);
    rect(105, 115, 220, 260);
    frame_end_seq();
    expect_ch("drift2", 0, 105, 115, 220, 260, 10, 40, 2);
    expect_ch("ch1_lost", 1, 0, 0, 0, 0, 0, 0, 3);

    // Object jumps just past the window's right edge (270)
    for (int x = 271; x <= 275; x++) px(x, 110, 1'b1, 1'b0);
    frame_end_seq();
    expect_ch("miss1", 0, 105, 115, 220, 260, 10, 40, 2);
    check("miss1_count", m_miss[0], 1);
    idle(5);
    frame_end_seq();
    expect_ch("miss2", 0, 105, 115, 220, 260, 10, 40, 2);
    idle(5);
    frame_end_seq();
    expect_ch("miss3", 0, 105, 115, 220, 260, 10, 40, 3);

    // Window clamps at the image origin; x=-1 wraps to 2047 and must not count
    set_seed(0, 4, 20, 3, 30);
    set_seed(1, 200, 220, 200, 220);
    do_lock(1'b0);
    px(0, 0, 1'b1, 1'b0);
    px(2047, 0, 1'b1, 1'b0);
    px(40, 30, 1'b1, 1'b0);
    px(41, 30, 1'b1, 1'b0);
    px(40, 31, 1'b1, 1'b0);
    frame_end_seq();
    expect_ch("clamp0", 0, 0, 30, 0, 40, 30, 40, 2);
    check("clamp1_state", int'(trk_state[3:2]), 1);

    // Overlapping windows: shared pixel goes to ch0 only
    set_seed(0, 100, 120, 100, 120);
    set_seed(1, 110, 140, 110, 140);
    do_lock(1'b0);
    px(115, 115, 1'b1, 1'b0);
    px(145, 145, 1'b1, 1'b0);
    px(95, 95, 1'b1, 1'b0);
    frame_end_seq();
    expect_ch("ovl0", 0, 95, 115, 95, 115, 20, 20, 2);
    expect_ch("ovl1", 1, 145, 145, 145, 145, 0, 0, 2);

    // Lock on the frame-end cycle discards the pending commit
    set_seed(0, 200, 210, 200, 210);
    set_seed(1, 300, 310, 300, 310);
    px(118, 118, 1'b1, 1'b0);
    do_lock(1'b1);
    expect_ch("coinc0", 0, 95, 115, 95, 115, 20, 20, 1);
    expect_ch("coinc1", 1, 145, 145, 145, 145, 0, 0, 1);
    px(205, 205, 1'b0, 1'b0);
    px(305, 305, 1'b0, 1'b0);
    px(205, 206, 1'b1, 1'b1);
    frame_end_seq();
    expect_ch("nohit0", 0, 95, 115, 95, 115, 20, 20, 1);
    check("nohit_miss0", m_miss[0], 1);
    px(205, 205, 1'b1, 1'b0);
    px(204, 207, 1'b1, 1'b0);
    frame_end_seq();
    expect_ch("reacq0", 0, 205, 207, 204, 205, 2, 1, 2);

    // Reset in mid-frame: nothing commits afterwards without a new lock
    px(206, 206, 1'b1, 1'b0);
    module_rst = 1'b1;
    @(posedge module_clk); #1;
    m_reset();
    module_rst = 1'b0;
    px(206, 206, 1'b1, 1'b0);
    frame_end_seq();
    expect_ch("rstmid0", 0, 0, 0, 0, 0, 0, 0, 0);
    expect_ch("rstmid1", 1, 0, 0, 0, 0, 0, 0, 0);

    idle(2);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
